// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction at a time into the PC and the register file.
// Loads are held in WAIT_MEM until read data returns, then aligned and extended.
module writeback_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned COUNTER_W  = 64,
   localparam int unsigned LANE_W    = $clog2(XLEN / 8)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  ready,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [XLEN-3:0]       next_pc,
   input  logic                  rd_value_write_enable,
   input  logic [XLEN-1:0]       rd_value_write_data,
   input  logic                  read_issued,
   input  logic [1:0]            load_size,
   input  logic                  load_signed,
   input  logic [LANE_W-1:0]     load_addr_low,
   input  logic [XLEN-1:0]       mem_read_data,
   input  logic                  mem_read_data_valid,
   output logic [XLEN-1:0]       pc_write_data,
   output logic                  pc_write_enable,
   output logic                  register_file_write_enable,
   output logic [REG_ADDR_W-1:0] register_file_write_addr,
   output logic [XLEN-1:0]       register_file_write_data,
   output logic [COUNTER_W-1:0]  retired_count
);

   localparam int unsigned ShW = LANE_W + 3;
   // Clearing low shift bits aligns half/word lanes; for XLEN=32 the word mask is zero.
   localparam logic [ShW-1:0] HalfMask = ~ShW'(15);
   localparam logic [ShW-1:0] WordMask = ~ShW'(31);

   typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

   state_e                  state_q;
   logic [REG_ADDR_W-1:0]   rd_q;
   logic [XLEN-3:0]         pc_q;
   logic [1:0]              size_q;
   logic                    signed_q;
   logic [LANE_W-1:0]       off_q;
   logic [COUNTER_W-1:0]    retired_count_q;

   logic                    in_idle;
   logic                    alu_retire;
   logic                    live_load;
   logic                    wait_load;
   logic                    load_start;
   logic                    retire;
   logic                    rf_we;
   logic [REG_ADDR_W-1:0]   sel_rd;
   logic [XLEN-3:0]         sel_pc;
   logic [1:0]              sel_size;
   logic                    sel_signed;
   logic [LANE_W-1:0]       sel_off;
   logic [ShW-1:0]          sh_b;
   logic [ShW-1:0]          sh;
   int unsigned             nbits;
   logic [XLEN-1:0]         shifted;
   logic                    sign_bit;
   logic [XLEN-1:0]         keep_mask;
   logic [XLEN-1:0]         load_data;

   always_comb begin
      in_idle    = (state_q == StIdle);
      alu_retire = reset_n && in_idle && enable && !read_issued;
      live_load  = reset_n && in_idle && enable && read_issued && mem_read_data_valid;
      wait_load  = reset_n && !in_idle && mem_read_data_valid;
      load_start = reset_n && in_idle && enable && read_issued && !mem_read_data_valid;
      retire     = alu_retire || live_load || wait_load;
      rf_we      = alu_retire ? rd_value_write_enable : (live_load || wait_load);

      sel_rd     = in_idle ? rd            : rd_q;
      sel_pc     = in_idle ? next_pc       : pc_q;
      sel_size   = in_idle ? load_size     : size_q;
      sel_signed = in_idle ? load_signed   : signed_q;
      sel_off    = in_idle ? load_addr_low : off_q;
   end

   always_comb begin
      sh_b     = {sel_off, 3'b000};
      sh       = sh_b;
      nbits    = 8;
      shifted  = '0;
      sign_bit = 1'b0;
      unique case (sel_size)
         2'b00: begin
            sh    = sh_b;
            nbits = 8;
         end
         2'b01: begin
            sh    = sh_b & HalfMask;
            nbits = 16;
         end
         2'b10: begin
            sh    = sh_b & WordMask;
            nbits = 32;
         end
         2'b11: begin
            // Doubleword only exists on 64-bit; 32-bit treats it as a word.
            sh    = (XLEN == 64) ? '0 : (sh_b & WordMask);
            nbits = (XLEN == 64) ? XLEN : 32;
         end
      endcase
      shifted = mem_read_data >> sh;
      unique case (sel_size)
         2'b00:   sign_bit = shifted[7];
         2'b01:   sign_bit = shifted[15];
         2'b10:   sign_bit = shifted[31];
         default: sign_bit = (XLEN == 64) ? shifted[XLEN-1] : shifted[31];
      endcase
      // Shifting by XLEN yields zero, so the mask becomes all-ones for full-width loads.
      keep_mask = (XLEN'(1) << nbits) - XLEN'(1);
      load_data = (shifted & keep_mask) | ({XLEN{sel_signed & sign_bit}} & ~keep_mask);
   end

   always_comb begin
      ready                      = reset_n && in_idle;
      pc_write_enable            = retire;
      pc_write_data              = retire ? {sel_pc, 2'b00} : '0;
      register_file_write_enable = rf_we;
      register_file_write_addr   = rf_we ? sel_rd : '0;
      register_file_write_data   = '0;
      if (rf_we) begin
         register_file_write_data = alu_retire ? rd_value_write_data : load_data;
      end
      retired_count = retired_count_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         rd_q            <= '0;
         pc_q            <= '0;
         size_q          <= '0;
         signed_q        <= 1'b0;
         off_q           <= '0;
         retired_count_q <= '0;
      end else begin
         if (retire) begin
            retired_count_q <= retired_count_q + COUNTER_W'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (load_start) begin
                  rd_q     <= rd;
                  pc_q     <= next_pc;
                  size_q   <= load_size;
                  signed_q <= load_signed;
                  off_q    <= load_addr_low;
                  state_q  <= StWaitMem;
               end
            end
            StWaitMem: begin
               if (mem_read_data_valid) begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: a 32-bit instance and a 64-bit instance with a 4-bit counter.
// Expected retirements are queued when stimulus is driven and popped when the PC strobe fires.
module tb_writeback_stage;

   typedef struct {
      string       name;
      logic [63:0] pc;
      logic        rf_we;
      logic [4:0]  addr;
      logic [63:0] data;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_cnt = '0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        a_ready, a_enable, a_rf_wen, a_read_issued, a_load_signed, a_mem_valid;
   logic [4:0]  a_rd;
   logic [29:0] a_next_pc;
   logic [31:0] a_rf_wdata, a_mem_data;
   logic [1:0]  a_load_size;
   logic [1:0]  a_off;
   logic [31:0] a_pc_wd, a_rf_wd;
   logic        a_pc_we, a_rf_we;
   logic [4:0]  a_rf_wa;
   logic [63:0] a_cnt;

   // 64-bit instance
   logic        b_ready, b_enable, b_rf_wen, b_read_issued, b_load_signed, b_mem_valid;
   logic [4:0]  b_rd;
   logic [61:0] b_next_pc;
   logic [63:0] b_rf_wdata, b_mem_data;
   logic [1:0]  b_load_size;
   logic [2:0]  b_off;
   logic [63:0] b_pc_wd, b_rf_wd;
   logic        b_pc_we, b_rf_we;
   logic [4:0]  b_rf_wa;
   logic [3:0]  b_cnt;

   writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .COUNTER_W(64)) u_a (
      .clk(clk), .reset_n(reset_n), .ready(a_ready), .enable(a_enable), .rd(a_rd),
      .next_pc(a_next_pc), .rd_value_write_enable(a_rf_wen), .rd_value_write_data(a_rf_wdata),
      .read_issued(a_read_issued), .load_size(a_load_size), .load_signed(a_load_signed),
      .load_addr_low(a_off), .mem_read_data(a_mem_data), .mem_read_data_valid(a_mem_valid),
      .pc_write_data(a_pc_wd), .pc_write_enable(a_pc_we),
      .register_file_write_enable(a_rf_we), .register_file_write_addr(a_rf_wa),
      .register_file_write_data(a_rf_wd), .retired_count(a_cnt)
   );

   writeback_stage #(.XLEN(64), .REG_ADDR_W(5), .COUNTER_W(4)) u_b (
      .clk(clk), .reset_n(reset_n), .ready(b_ready), .enable(b_enable), .rd(b_rd),
      .next_pc(b_next_pc), .rd_value_write_enable(b_rf_wen), .rd_value_write_data(b_rf_wdata),
      .read_issued(b_read_issued), .load_size(b_load_size), .load_signed(b_load_signed),
      .load_addr_low(b_off), .mem_read_data(b_mem_data), .mem_read_data_valid(b_mem_valid),
      .pc_write_data(b_pc_wd), .pc_write_enable(b_pc_we),
      .register_file_write_enable(b_rf_we), .register_file_write_addr(b_rf_wa),
      .register_file_write_data(b_rf_wd), .retired_count(b_cnt)
   );

   task automatic idle_a();
      a_enable = 0; a_rf_wen = 0; a_read_issued = 0; a_load_signed = 0; a_mem_valid = 0;
      a_rd = '0; a_next_pc = '0; a_rf_wdata = '0; a_mem_data = '0; a_load_size = '0;
      a_off = '0;
   endtask

   task automatic idle_b();
      b_enable = 0; b_rf_wen = 0; b_read_issued = 0; b_load_signed = 0; b_mem_valid = 0;
      b_rd = '0; b_next_pc = '0; b_rf_wdata = '0; b_mem_data = '0; b_load_size = '0;
      b_off = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_a();
      idle_b();
      reset_n = 0;
      a_enable = 1; a_rf_wen = 1; a_rd = 5'd3; a_rf_wdata = 32'h1234_5678; a_next_pc = 30'h55;
      @(negedge clk);
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", a_ready); end
      total++; if (a_pc_we !== 1'b0 || a_rf_we !== 1'b0) begin
         bad++; $display("FAIL reset_strobes: pc_we=%b rf_we=%b want 0 0", a_pc_we, a_rf_we);
      end
      total++; if (a_rf_wa !== 5'd0 || a_rf_wd !== 32'd0 || a_pc_wd !== 32'd0) begin
         bad++; $display("FAIL reset_outputs: addr=%h data=%h pc=%h want zeros", a_rf_wa, a_rf_wd, a_pc_wd);
      end
      total++; if (a_cnt !== 64'd0 || b_cnt !== 4'd0) begin
         bad++; $display("FAIL reset_count: a=%0d b=%0d want 0 0", a_cnt, b_cnt);
      end
      idle_a();
      next_cycle();
      reset_n = 1;
      @(negedge clk);
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
         bad++; $display("FAIL ready_after_reset: a=%b b=%b want 1 1", a_ready, b_ready);
      end
      next_cycle();
   endtask

   // Back-to-back ALU retires, including one without an rd write and one to x0.
   task automatic test_alu_back_to_back();
      logic [4:0]  t_rd [3] = '{5'd5, 5'd6, 5'd0};
      logic        t_we [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] t_d  [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
      logic [31:0] t_pc [3] = '{32'h100, 32'h104, 32'h108};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         idle_a();
         a_enable = 1; a_rd = t_rd[i]; a_rf_wen = t_we[i]; a_rf_wdata = t_d[i];
         a_next_pc = t_pc[i][31:2];
         a_mem_data = $urandom;
         sb.push_back('{"alu", {32'd0, t_pc[i]}, t_we[i], t_rd[i], {32'd0, t_d[i]}});
         @(negedge clk);
         total++; if (a_cnt !== exp_cnt) begin bad++; $display("FAIL alu_count_before: got %0d want %0d", a_cnt, exp_cnt); end
         total++;
         if (a_pc_we !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL alu_retire: pc_we=%b queued=%0d want 1 and nonempty", a_pc_we, sb.size());
         end else begin
            e = sb.pop_front();
            total++; if ({32'd0, a_pc_wd} !== e.pc) begin bad++; $display("FAIL %s_pc: got %h want %h", e.name, a_pc_wd, e.pc); end
            total++; if (a_rf_we !== e.rf_we) begin bad++; $display("FAIL %s_rf_we: got %b want %b", e.name, a_rf_we, e.rf_we); end
            if (e.rf_we) begin
               total++;
               if (a_rf_wa !== e.addr || {32'd0, a_rf_wd} !== e.data) begin
                  bad++; $display("FAIL %s_rf: got x%0d=%h want x%0d=%h", e.name, a_rf_wa, a_rf_wd, e.addr, e.data);
               end
            end
         end
         next_cycle();
         exp_cnt++;
      end
      idle_a();
      @(negedge clk);
      total++; if (a_cnt !== exp_cnt) begin bad++; $display("FAIL alu_count_after: got %0d want %0d", a_cnt, exp_cnt); end
      next_cycle();
   endtask

   // LB signed from lane 2, data 3 cycles later, with junk on the instruction inputs meanwhile.
   task automatic test_delayed_load();
      int   ready_low = 0;
      int   pc_writes = 0;
      exp_t e;
      idle_a();
      a_enable = 1; a_read_issued = 1; a_load_size = 2'b00; a_load_signed = 1; a_off = 2'd2;
      a_rd = 5'd7; a_next_pc = 30'h80; a_rf_wen = 0;
      sb.push_back('{"delayed_lb", 64'h200, 1'b1, 5'd7, 64'hFFFF_FF80});
      @(negedge clk);
      total++; if (a_pc_we !== 1'b0 || a_rf_we !== 1'b0 || a_ready !== 1'b1) begin
         bad++; $display("FAIL load_issue: pc_we=%b rf_we=%b ready=%b want 0 0 1", a_pc_we, a_rf_we, a_ready);
      end
      next_cycle();
      for (int i = 1; i <= 3; i++) begin
         a_enable = 1'($urandom); a_rd = 5'($urandom); a_next_pc = 30'($urandom);
         a_read_issued = 1'($urandom); a_load_size = 2'($urandom); a_off = 2'($urandom);
         a_load_signed = 1'($urandom); a_rf_wen = 1'($urandom); a_rf_wdata = $urandom;
         a_mem_valid = (i == 3);
         a_mem_data = (i == 3) ? 32'h1280_FF00 : $urandom;
         @(negedge clk);
         if (a_ready !== 1'b1) ready_low++;
         if (a_pc_we === 1'b1) pc_writes++;
         if (i < 3) begin
            total++; if (a_pc_we !== 1'b0 || a_rf_we !== 1'b0) begin
               bad++; $display("FAIL wait_strobe: cycle %0d pc_we=%b rf_we=%b want 0 0", i, a_pc_we, a_rf_we);
            end
         end else begin
            total++;
            if (a_pc_we !== 1'b1 || sb.size() == 0) begin
               bad++; $display("FAIL delayed_retire: pc_we=%b queued=%0d want 1 and nonempty", a_pc_we, sb.size());
            end else begin
               e = sb.pop_front();
               total++; if ({32'd0, a_pc_wd} !== e.pc) begin bad++; $display("FAIL %s_pc: got %h want %h", e.name, a_pc_wd, e.pc); end
               total++;
               if (a_rf_we !== 1'b1 || a_rf_wa !== e.addr || {32'd0, a_rf_wd} !== e.data) begin
                  bad++; $display("FAIL %s_rf: got we=%b x%0d=%h want x%0d=%h", e.name, a_rf_we, a_rf_wa, a_rf_wd, e.addr, e.data);
               end
            end
         end
         next_cycle();
      end
      idle_a();
      exp_cnt++;
      @(negedge clk);
      total++; if (ready_low != 3) begin bad++; $display("FAIL wait_ready_cycles: got %0d want 3", ready_low); end
      total++; if (pc_writes != 1) begin bad++; $display("FAIL delayed_pc_writes: got %0d want 1", pc_writes); end
      total++; if (a_ready !== 1'b1 || a_cnt !== exp_cnt) begin
         bad++; $display("FAIL delayed_after: ready=%b count=%0d want 1 %0d", a_ready, a_cnt, exp_cnt);
      end
      next_cycle();
   endtask

   // Loads whose data is valid in the issuing cycle; rd_value_write_enable is held low.
   task automatic test_same_cycle_loads();
      logic [1:0]  t_sz [7] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      logic        t_sg [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [1:0]  t_of [7] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0};
      logic [31:0] t_d  [7] = '{32'hBEEF_1234, 32'h8012_3456, 32'h0000_A500, 32'h1234_8001,
                                32'h0000_7FFF, 32'h8765_4321, 32'hF000_0000};
      logic [31:0] t_x  [7] = '{32'h0000_BEEF, 32'hFFFF_FF80, 32'h0000_00A5, 32'hFFFF_8001,
                                32'h0000_7FFF, 32'h8765_4321, 32'hF000_0000};
      logic [31:0] pc;
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         pc = 32'h300 + 32'(4 * i);
         idle_a();
         a_enable = 1; a_read_issued = 1; a_mem_valid = 1; a_rf_wen = 0;
         a_load_size = t_sz[i]; a_load_signed = t_sg[i]; a_off = t_of[i]; a_mem_data = t_d[i];
         a_rd = 5'(9 + i); a_next_pc = pc[31:2]; a_rf_wdata = $urandom;
         sb.push_back('{"same_cycle_load", {32'd0, pc}, 1'b1, 5'(9 + i), {32'd0, t_x[i]}});
         @(negedge clk);
         total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL same_cycle_ready: case %0d got %b want 1", i, a_ready); end
         total++;
         if (a_pc_we !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL same_cycle_retire: case %0d pc_we=%b want 1", i, a_pc_we);
         end else begin
            e = sb.pop_front();
            total++; if ({32'd0, a_pc_wd} !== e.pc) begin bad++; $display("FAIL %s_pc: case %0d got %h want %h", e.name, i, a_pc_wd, e.pc); end
            total++;
            if (a_rf_we !== 1'b1 || a_rf_wa !== e.addr || {32'd0, a_rf_wd} !== e.data) begin
               bad++; $display("FAIL %s_rf: case %0d got we=%b x%0d=%h want x%0d=%h", e.name, i, a_rf_we, a_rf_wa, a_rf_wd, e.addr, e.data);
            end
         end
         next_cycle();
         exp_cnt++;
      end
      idle_a();
      @(negedge clk);
      total++; if (a_ready !== 1'b1 || a_cnt !== exp_cnt) begin
         bad++; $display("FAIL same_cycle_after: ready=%b count=%0d want 1 %0d", a_ready, a_cnt, exp_cnt);
      end
      next_cycle();
   endtask

   task automatic test_spurious_valid();
      idle_a();
      a_mem_valid = 1; a_mem_data = $urandom; a_read_issued = 1; a_rd = 5'd4; a_rf_wen = 1;
      @(negedge clk);
      total++; if (a_pc_we !== 1'b0 || a_rf_we !== 1'b0) begin
         bad++; $display("FAIL spurious_strobe: pc_we=%b rf_we=%b want 0 0", a_pc_we, a_rf_we);
      end
      next_cycle();
      idle_a();
      @(negedge clk);
      total++; if (a_ready !== 1'b1 || a_cnt !== exp_cnt) begin
         bad++; $display("FAIL spurious_state: ready=%b count=%0d want 1 %0d", a_ready, a_cnt, exp_cnt);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_load();
      idle_a();
      a_enable = 1; a_read_issued = 1; a_rd = 5'd11; a_next_pc = 30'h1FF; a_load_size = 2'b10;
      next_cycle();
      idle_a();
      @(negedge clk);
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL midload_wait: ready=%b want 0", a_ready); end
      #1 reset_n = 0;
      #1;
      total++; if (a_ready !== 1'b0 || a_pc_we !== 1'b0 || a_rf_we !== 1'b0) begin
         bad++; $display("FAIL midload_in_reset: ready=%b pc_we=%b rf_we=%b want 0 0 0", a_ready, a_pc_we, a_rf_we);
      end
      next_cycle();
      reset_n = 1;
      exp_cnt = '0;
      a_mem_valid = 1; a_mem_data = 32'hFFFF_FFFF;
      @(negedge clk);
      total++; if (a_pc_we !== 1'b0 || a_rf_we !== 1'b0) begin
         bad++; $display("FAIL midload_dropped: pc_we=%b rf_we=%b want 0 0", a_pc_we, a_rf_we);
      end
      next_cycle();
      idle_a();
      @(negedge clk);
      total++; if (a_ready !== 1'b1 || a_cnt !== 64'd0) begin
         bad++; $display("FAIL midload_after: ready=%b count=%0d want 1 0", a_ready, a_cnt);
      end
      next_cycle();
   endtask

   task automatic test_xlen64();
      logic [1:0]  t_sz [5] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
      logic        t_sg [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0]  t_of [5] = '{3'd4, 3'd0, 3'd0, 3'd7, 3'd6};
      logic [63:0] t_d  [5] = '{64'h8000_0000_0000_0000, 64'h8877_6655_4433_2211,
                                64'h8000_0000_DEAD_BEEF, 64'h7F00_0000_0000_0000,
                                64'h8001_0000_0000_0000};
      logic [63:0] t_x  [5] = '{64'hFFFF_FFFF_8000_0000, 64'h8877_6655_4433_2211,
                                64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_007F,
                                64'hFFFF_FFFF_FFFF_8001};
      logic [63:0] pc;
      exp_t e;
      idle_b();
      for (int i = 0; i < 16; i++) begin
         b_enable = 1; b_rd = 5'(i); b_rf_wen = 1; b_rf_wdata = {$urandom, $urandom};
         b_next_pc = 62'(i + 1);
         @(negedge clk);
         total++; if (b_cnt !== 4'(i) || b_pc_we !== 1'b1) begin
            bad++; $display("FAIL x64_alu: retire %0d count=%0d pc_we=%b want %0d 1", i, b_cnt, b_pc_we, i);
         end
         next_cycle();
      end
      idle_b();
      @(negedge clk);
      total++; if (b_cnt !== 4'd0) begin bad++; $display("FAIL x64_wrap: got %0d want 0", b_cnt); end
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         pc = 64'h1000 + 64'(8 * i);
         idle_b();
         b_enable = 1; b_read_issued = 1; b_load_size = t_sz[i]; b_load_signed = t_sg[i];
         b_off = t_of[i]; b_rd = 5'(20 + i); b_next_pc = pc[63:2];
         sb.push_back('{"x64_load", pc, 1'b1, 5'(20 + i), t_x[i]});
         if (i == 0) begin
            // First load waits one cycle for data with junk on the instruction inputs.
            @(negedge clk);
            total++; if (b_pc_we !== 1'b0 || b_rf_we !== 1'b0) begin
               bad++; $display("FAIL x64_issue: pc_we=%b rf_we=%b want 0 0", b_pc_we, b_rf_we);
            end
            next_cycle();
            b_rd = 5'($urandom); b_next_pc = 62'($urandom); b_off = 3'($urandom);
            b_load_size = 2'($urandom); b_load_signed = 1'($urandom);
         end
         b_mem_valid = 1; b_mem_data = t_d[i];
         @(negedge clk);
         total++;
         if (b_pc_we !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL x64_retire: case %0d pc_we=%b want 1", i, b_pc_we);
         end else begin
            e = sb.pop_front();
            total++; if (b_pc_wd !== e.pc) begin bad++; $display("FAIL %s_pc: case %0d got %h want %h", e.name, i, b_pc_wd, e.pc); end
            total++;
            if (b_rf_we !== 1'b1 || b_rf_wa !== e.addr || b_rf_wd !== e.data) begin
               bad++; $display("FAIL %s_rf: case %0d got we=%b x%0d=%h want x%0d=%h", e.name, i, b_rf_we, b_rf_wa, b_rf_wd, e.addr, e.data);
            end
         end
         next_cycle();
      end
      idle_b();
      @(negedge clk);
      total++; if (b_cnt !== 4'd5 || b_ready !== 1'b1) begin
         bad++; $display("FAIL x64_after: count=%0d ready=%b want 5 1", b_cnt, b_ready);
      end
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_delayed_load();
      test_same_cycle_loads();
      test_spurious_valid();
      test_reset_mid_load();
      test_xlen64();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
